ft_in_fifo: RTL
===============

Name: ft_in_fifo

Overview:
- Single-clock synchronous FIFO that buffers bytes from the FT2232 FIFO interface block (write side) to the host-command consumer logic (read side).
- Provides the full / almost-full back-pressure flags the interface block checks before each FT2232 read.
- A second instance is the OUT FIFO that feeds the interface block's write path; that instance uses the empty flag and registered read data.
- Adds a level count and sticky overflow/underflow error flags for bring-up and debug LEDs.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- ADDR_WIDTH, 9, log2 of depth; DEPTH = 2**ADDR_WIDTH = 512.
- AFULL_MARGIN, 4, afull_o asserts when level >= DEPTH - AFULL_MARGIN; legal range 2..DEPTH-1.
- AEMPTY_MARGIN, 2, aempty_o asserts when level <= AEMPTY_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk_i  input  1  single clock for both sides; connected to fifo_clk from the FT2232.
- reset_i  input  1  asynchronous, active-high reset.
- wr_en_i  input  1  write request, sampled on rising clk_i.
- wr_data_i  input  DATA_WIDTH  write data, sampled with wr_en_i.
- full_o  output  1  level == DEPTH.
- afull_o  output  1  almost full (see AFULL_MARGIN).
- rd_en_i  input  1  read request, sampled on rising clk_i.
- rd_data_o  output  DATA_WIDTH  registered read data.
- empty_o  output  1  level == 0.
- aempty_o  output  1  almost empty (see AEMPTY_MARGIN).
- level_o  output  ADDR_WIDTH+1  current entry count, 0..DEPTH.
- overflow_o  output  1  sticky; set by a write attempted while full.
- underflow_o  output  1  sticky; set by a read attempted while empty.
- clear_err_i  input  1  synchronous clear of overflow_o and underflow_o.

Behaviour:
- Reset (async assert, sync-to-clock deassert by the top level):
  - write pointer, read pointer and level cleared to 0.
  - full_o=0, afull_o=0, empty_o=1, aempty_o=1, overflow_o=0, underflow_o=0, rd_data_o=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Pointers: ADDR_WIDTH bits, wrap naturally from DEPTH-1 to 0.
- Level: a separate ADDR_WIDTH+1-bit counter. All flags are registered and computed from the next-level value, so they change in the same cycle as level_o and carry no extra cycle of lag.
- Write accepted when wr_en_i=1 and full_o=0:
  - mem[wptr] <= wr_data_i; wptr increments.
  - If full_o=1 the write is dropped, no state changes except overflow_o <= 1.
- Read accepted when rd_en_i=1 and empty_o=0:
  - rd_data_o <= mem[rptr] on that edge; rptr increments.
  - Data is therefore valid the cycle after rd_en_i is sampled high.
  - rd_data_o holds its value on all other cycles.
  - If empty_o=1 the read is dropped, rd_data_o holds, underflow_o <= 1.
- Simultaneous read and write:
  - Both accepted (neither full nor empty): level unchanged, both pointers advance.
  - While empty: the write is accepted, the read is rejected and flags underflow; level becomes 1; no write-through bypass.
  - While full: the read is accepted, the write is rejected and flags overflow; level becomes DEPTH-1.
- Level update: level_next = level + accepted_write - accepted_read.
  - full_o = (level_next == DEPTH)
  - empty_o = (level_next == 0)
  - afull_o = (level_next >= DEPTH-AFULL_MARGIN)
  - aempty_o = (level_next <= AEMPTY_MARGIN)
- Write-side contract: a writer that stops on afull_o may issue up to AFULL_MARGIN-1 further writes with no loss. The FT2232 interface issues at most 1 write after sampling afull, so AFULL_MARGIN >= 2 is mandatory.
- clear_err_i=1 clears both sticky flags. If a new error occurs in the same cycle, that flag stays set (set wins).
- Memory is inferred as one synchronous write/read RAM (EBR on ECP5). No read-during-write hazard arises, because a read never targets the slot being written: that would require the FIFO to be empty, and a read while empty is rejected.

Test Plan:
- Reset then idle: level_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, rd_data_o=0; no flag toggles for 10 cycles.
- Write 0x00..0xFF then 0x00..0xFF (512 writes):
  - afull_o rises on the edge where level reaches 508.
  - full_o rises at 512.
  - A 513th write leaves level at 512 and sets overflow_o.
- Read all 512 entries back: rd_data_o sequence 0x00..0xFF, 0x00..0xFF, each one cycle after rd_en_i. empty_o rises with the last read. One further read sets underflow_o and rd_data_o holds 0xFF.
- Wrap and simultaneous traffic: prefill 3, then 1000 cycles of concurrent write (incrementing byte) and read. Level stays at 3, output order matches input order, and both pointers wrap at least once.
- Edge cases:
  - Concurrent rd/wr while empty: level becomes 1 and underflow_o=1.
  - Concurrent rd/wr while full: level becomes 511 and overflow_o=1.
  - Pulse clear_err_i: both flags clear.
- Mid-stream async reset with level=100: all outputs return to reset values immediately, with no clock edge required; the next write/read pair returns the new byte.

Source files
------------

// File: rtl/ft_in_fifo.sv
// Single-clock byte FIFO between the FT2232 interface block and the host-command logic.
// Registered read data, level count, registered flags and sticky overflow/underflow indicators.
module ft_in_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int AFULL_MARGIN  = 4,
  parameter int AEMPTY_MARGIN = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  afull_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  aempty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clear_err_i
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LVL_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AFULL_TH  = LVL_FULL - (ADDR_WIDTH+1)'(AFULL_MARGIN);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_TH = (ADDR_WIDTH+1)'(AEMPTY_MARGIN);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH:0]   w_level_next;
  logic                  w_overflow_next;
  logic                  w_underflow_next;

  assign w_wr_ok = wr_en_i & ~r_full;
  assign w_rd_ok = rd_en_i & ~r_empty;

  always_comb begin
    w_level_next = r_level;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // A new error in the same cycle as a clear keeps its flag set.
  assign w_overflow_next  = (r_overflow  & ~clear_err_i) | (wr_en_i & r_full);
  assign w_underflow_next = (r_underflow & ~clear_err_i) | (rd_en_i & r_empty);

  // RAM contents are deliberately left out of reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_rd_data   <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + PTR_ONE;
      end
      r_level     <= w_level_next;
      r_full      <= (w_level_next == LVL_FULL);
      r_afull     <= (w_level_next >= AFULL_TH);
      r_empty     <= (w_level_next == '0);
      r_aempty    <= (w_level_next <= AEMPTY_TH);
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  assign full_o      = r_full;
  assign afull_o     = r_afull;
  assign empty_o     = r_empty;
  assign aempty_o    = r_aempty;
  assign level_o     = r_level;
  assign rd_data_o   = r_rd_data;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule
